// File: rtl/bht_update_queue.sv
// Resolved-branch update queue feeding the BHT: FIFO buffering, debug hold, flush and a saturating drop counter.
// Define BHT_UPDQ_BYPASS_EN to forward an input straight to the BHT when the queue is empty and draining.
module bht_update_queue #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic                       upd_valid_i,
    input  logic [VLEN-1:0]            upd_pc_i,
    input  logic                       upd_taken_i,
    output logic                       upd_ready_o,
    output logic                       bht_update_valid_o,
    output logic [VLEN-1:0]            bht_update_pc_o,
    output logic                       bht_update_taken_o,
    output logic                       write_ghr_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [CNT_W-1:0]           drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [VLEN-1:0]    r_pc_mem    [DEPTH];
    logic               r_taken_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_empty;
    logic               w_ready;
    logic               w_pop;
    logic               w_byp;
    logic               w_push;
    logic               w_drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 1'b1;
        end
    endfunction

    assign w_empty = (r_count == '0);

    // Space is judged on the registered count only; a same-cycle pop never frees room for a push.
    assign w_ready = (r_count < FULL_CNT) && (r_state != ST_FLUSH) && !flush_i;
    assign w_pop   = (r_state == ST_RUN) && !w_empty && !debug_mode_i && !flush_i;

`ifdef BHT_UPDQ_BYPASS_EN
    assign w_byp   = w_empty && (r_state == ST_RUN) && !debug_mode_i && !flush_i && upd_valid_i;
`else
    assign w_byp   = 1'b0;
`endif

    // A bypassed update is consumed by the BHT directly and never occupies a slot.
    assign w_push  = upd_valid_i && w_ready && !w_byp;
    assign w_drop  = upd_valid_i && !w_ready && !flush_i && (r_state != ST_FLUSH);

    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN:   if (debug_mode_i)  w_next_state = ST_HOLD;
                ST_HOLD:  if (!debug_mode_i) w_next_state = ST_RUN;
                ST_FLUSH: w_next_state = debug_mode_i ? ST_HOLD : ST_RUN;
                default:  w_next_state = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    // Entry storage carries no reset; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= upd_pc_i;
            r_taken_mem[r_wr_ptr] <= upd_taken_i;
        end
    end

    always_comb begin
        bht_update_pc_o    = '0;
        bht_update_taken_o = 1'b0;
        if (!w_empty) begin
            bht_update_pc_o    = r_pc_mem[r_rd_ptr];
            bht_update_taken_o = r_taken_mem[r_rd_ptr];
        end else if (w_byp) begin
            bht_update_pc_o    = upd_pc_i;
            bht_update_taken_o = upd_taken_i;
        end
    end

    assign bht_update_valid_o = w_pop || w_byp;
    assign write_ghr_o        = w_pop || w_byp;
    assign upd_ready_o        = w_ready;
    assign occupancy_o        = r_count;
    assign drop_cnt_o         = r_drop_cnt;

endmodule
